// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dm_arb_pkg;

  localparam int unsigned DefaultAw = 10;
  localparam int unsigned DefaultDw = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

endpackage

// File: rtl/dm_arb_pick.sv
// Two-way winner select: A wins unless only B requests, or both request and ptr favours B.
module dm_arb_pick (
  input  logic ReqA,
  input  logic ReqB,
  input  logic ptr,
  output logic pick_b
);

  always_comb begin
    pick_b = ReqB & (~ReqA | ptr);
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-requester single-port data-memory arbiter: IDLE/ISSUE/RESP, one access per 2 cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin between A and B; default is fixed priority to A.
module data_memory_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW = DefaultAw,
  parameter int unsigned DW = DefaultDw
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          ReqA,
  input  logic          WriteA,
  input  logic [AW-1:0] AddrA,
  input  logic [DW-1:0] WDataA,
  output logic          GntA,
  output logic          ValidA,
  output logic [DW-1:0] RDataA,
  input  logic          ReqB,
  input  logic          WriteB,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] WDataB,
  output logic          GntB,
  output logic          ValidB,
  output logic [DW-1:0] RDataB,
  output logic [AW-1:0] MemAddress,
  output logic [DW-1:0] MemWriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] MemReadData,
  output logic          Busy
);

  state_t        state_q;
  logic          win_b_q;
  logic          wr_q;
  logic          ptr;
  logic          pick_b;
  logic          arb;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_q set means B is favoured on the next contested grant.
  logic ptr_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_q <= 1'b0;
    end else if (arb) begin
      ptr_q <= ~pick_b;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  dm_arb_pick u_pick (
    .ReqA  (ReqA),
    .ReqB  (ReqB),
    .ptr   (ptr),
    .pick_b(pick_b)
  );

  always_comb begin
    arb       = (state_q != ISSUE) && (ReqA || ReqB);
    sel_write = pick_b ? WriteB : WriteA;
    sel_addr  = pick_b ? AddrB : AddrA;
    sel_wdata = pick_b ? WDataB : WDataA;
    Busy      = (state_q != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      win_b_q      <= 1'b0;
      wr_q         <= 1'b0;
      GntA         <= 1'b0;
      GntB         <= 1'b0;
      ValidA       <= 1'b0;
      ValidB       <= 1'b0;
      RDataA       <= '0;
      RDataB       <= '0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
    end else begin
      GntA   <= 1'b0;
      GntB   <= 1'b0;
      ValidA <= 1'b0;
      ValidB <= 1'b0;
      case (state_q)
        ISSUE: begin
          MemWrite <= 1'b0;
          MemRead  <= 1'b0;
          state_q  <= RESP;
        end
        RESP: begin
          // A write echoes its own data since memory read data is undefined for writes.
          if (win_b_q) begin
            ValidB <= 1'b1;
            RDataB <= wr_q ? MemWriteData : MemReadData;
          end else begin
            ValidA <= 1'b1;
            RDataA <= wr_q ? MemWriteData : MemReadData;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (arb) begin
        win_b_q      <= pick_b;
        wr_q         <= sel_write;
        MemAddress   <= sel_addr;
        MemWriteData <= sel_wdata;
        MemWrite     <= sel_write;
        MemRead      <= ~sel_write;
        GntA         <= ~pick_b;
        GntB         <= pick_b;
        state_q      <= ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed vector table, reset/arbitration sequences, random run.
module tb_data_memory_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b1;
  logic          ReqA = 1'b0, WriteA = 1'b0, ReqB = 1'b0, WriteB = 1'b0;
  logic [AW-1:0] AddrA = '0, AddrB = '0;
  logic [DW-1:0] WDataA = '0, WDataB = '0;
  logic          GntA, ValidA, GntB, ValidB, MemWrite, MemRead, Busy;
  logic [DW-1:0] RDataA, RDataB, MemWriteData, MemReadData;
  logic [AW-1:0] MemAddress;

  int checks = 0;
  int errors = 0;

  data_memory_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqA(ReqA), .WriteA(WriteA), .AddrA(AddrA), .WDataA(WDataA),
    .GntA(GntA), .ValidA(ValidA), .RDataA(RDataA),
    .ReqB(ReqB), .WriteB(WriteB), .AddrB(AddrB), .WDataB(WDataB),
    .GntB(GntB), .ValidB(ValidB), .RDataB(RDataB),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemReadData(MemReadData), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Synchronous memory: acts on the command it samples at the posedge.
  logic [DW-1:0] mem [1024];
  bit            mem_ready;
  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000 + i;
      mem_ready <= 1'b1;
    end else begin
      if (MemWrite) mem[MemAddress] <= MemWriteData;
      if (MemRead) MemReadData <= mem[MemAddress];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  // Transaction-level reference: one access in flight, effect one edge after accept,
  // response two edges after accept, next accept allowed from the response edge.
  logic [DW-1:0] ref_mem [1024];
  int            n, free_edge, mem_due, resp_due;
  bit            cmd_pend, resp_pend, cmd_wr, cmd_b, last_b;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, resp_data;
  logic          e_gnta, e_gntb, e_va, e_vb, e_mw, e_mr, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_rda, e_rdb;

  task automatic model_reset();
    n = 0; free_edge = 0; cmd_pend = 0; resp_pend = 0; last_b = 1;
    e_rda = '0; e_rdb = '0;
  endtask

  task automatic model_edge();
    bit b;
    e_gnta = 0; e_gntb = 0; e_va = 0; e_vb = 0; e_mw = 0; e_mr = 0;
    if (resp_pend && n == resp_due) begin
      resp_pend = 0;
      if (cmd_b) begin e_vb = 1; e_rdb = resp_data; end
      else begin e_va = 1; e_rda = resp_data; end
    end
    if (cmd_pend && n == mem_due) begin
      cmd_pend = 0;
      resp_pend = 1;
      if (cmd_wr) begin ref_mem[cmd_addr] = cmd_wdata; resp_data = cmd_wdata; end
      else resp_data = ref_mem[cmd_addr];
    end
    if ((ReqA || ReqB) && n >= free_edge) begin
`ifdef ARB_ROUND_ROBIN_EN
      b = (ReqA && ReqB) ? !last_b : ReqB;
`else
      b = ReqB && !ReqA;
`endif
      last_b    = b;
      cmd_b     = b;
      cmd_wr    = b ? WriteB : WriteA;
      cmd_addr  = b ? AddrB : AddrA;
      cmd_wdata = b ? WDataB : WDataA;
      cmd_pend  = 1;
      mem_due   = n + 1;
      resp_due  = n + 2;
      free_edge = n + 2;
      e_gnta = !b; e_gntb = b; e_mw = cmd_wr; e_mr = !cmd_wr; e_addr = cmd_addr;
    end
    e_busy = (n < free_edge);
    n++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    model_edge();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {GntA, GntB, ValidA, ValidB, MemWrite, MemRead, Busy};
  endfunction

  function automatic logic all_outs();
    return |{GntA, ValidA, RDataA, GntB, ValidB, RDataB, MemAddress, MemWriteData,
             MemWrite, MemRead, Busy};
  endfunction

  task automatic set_a(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    ReqA = r; WriteA = w; AddrA = a; WDataA = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    ReqB = r; WriteB = w; AddrB = a; WDataB = d;
  endtask

  typedef struct {
    logic          ra, wa;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          rb, wb;
    logic [AW-1:0] ab;
    logic [6:0]    ctl;  // GntA GntB ValidA ValidB MemWrite MemRead Busy
    logic [DW-1:0] rda, rdb;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 10'd993, 32'd22, 1'b0, 1'b0, 10'd0, 7'b1000101, 32'd0, 32'd0};
    tbl[1] = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 7'b0000001, 32'd0, 32'd0};
    tbl[2] = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 7'b0010000, 32'd22, 32'd0};
    tbl[3] = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd993, 7'b0100011, 32'd22, 32'd0};
    tbl[4] = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 7'b0000001, 32'd22, 32'd0};
    tbl[5] = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 7'b0001000, 32'd22, 32'd22};
    tbl[6] = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd993, 7'b0100011, 32'd22, 32'd22};
    // A pulsed only across the ISSUE edge must be ignored.
    tbl[7] = '{1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, 10'd0, 7'b0000001, 32'd22, 32'd22};
    tbl[8] = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 7'b0001000, 32'd22, 32'd22};
    tbl[9] = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 7'b0000000, 32'd22, 32'd22};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h1000 + i;
    model_reset();

    // Reset state.
    #1 Rst_n = 1'b0;
    #1 check("reset_outs", all_outs(), 0);
    repeat (3) @(posedge Clk);
    #1 check("reset_outs_held", all_outs(), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      set_a(tbl[i].ra, tbl[i].wa, tbl[i].aa, tbl[i].da);
      set_b(tbl[i].rb, tbl[i].wb, tbl[i].ab, '0);
      tick();
      check($sformatf("vec%0d_ctl", i), ctl(), tbl[i].ctl);
      check($sformatf("vec%0d_rda", i), RDataA, tbl[i].rda);
      check($sformatf("vec%0d_rdb", i), RDataB, tbl[i].rdb);
    end
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);

    // Both requesters held high from a fresh reset.
    Rst_n = 1'b0;
    #1 model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    set_a(1, 0, 10'd1, '0);
    set_b(1, 0, 10'd2, '0);
    for (int k = 0; k < 12; k++) begin
      logic [1:0] eg;
      tick();
      if (k % 2 != 0) eg = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      else eg = ((k / 2) % 2 != 0) ? 2'b01 : 2'b10;
`else
      else eg = 2'b10;
`endif
      check($sformatf("both_req_gnt%0d", k), {GntA, GntB}, eg);
    end
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    repeat (3) tick();

    // Write abandoned by reset before the memory samples it.
    set_a(1, 1, 10'd1023, -32'sd20);
    tick();
    check("abort_gnt", {GntA, MemWrite, MemAddress}, {1'b1, 1'b1, 10'd1023});
    set_a(0, 0, '0, '0);
    #3 Rst_n = 1'b0;
    #1 check("abort_reset_outs", all_outs(), 0);
    model_reset();
    repeat (2) @(posedge Clk);
    #1 check("abort_reset_held", all_outs(), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    set_a(1, 0, 10'd1023, '0);
    tick();
    check("post_reset_gnt", {GntA, ValidA}, 2'b10);
    set_a(0, 0, '0, '0);
    tick();
    check("post_reset_novalid", ValidA, 0);
    tick();
    check("old_value_valid", {ValidA, RDataA}, {1'b1, 32'h13FF});
    tick();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      tick();
      check("rand_ctl", ctl(), {e_gnta, e_gntb, e_va, e_vb, e_mw, e_mr, e_busy});
      check("rand_rda", RDataA, e_rda);
      check("rand_rdb", RDataB, e_rdb);
      if (e_mw || e_mr) check("rand_addr", MemAddress, e_addr);
      if (!ReqA || e_gnta)
        set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
              AW'($urandom_range(0, 15)), $urandom);
      if (!ReqB || e_gntb)
        set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
              AW'($urandom_range(0, 15)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, memory word-address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- Clk, in, 1: sole clock; all state changes on the posedge.
- Rst_n, in, 1: reset, asynchronous, active-low.
REQ-004 SHALL have requester A ports (pipeline MEM stage):
- ReqA, in, 1: access request.
- WriteA, in, 1: 1 = write, 0 = read.
- AddrA, in, AW: word address.
- WDataA, in, DW: write data.
- GntA, out, 1: one-cycle accept pulse.
- ValidA, out, 1: one-cycle response pulse.
- RDataA, out, DW: response data.
REQ-005 SHALL have requester B ports (loader/debug): ReqB, WriteB, AddrB, WDataB, GntB, ValidB and RDataB, with the same widths and meanings as A.
REQ-006 SHALL have memory-side ports:
- MemAddress, out, AW.
- MemWriteData, out, DW.
- MemWrite, out, 1.
- MemRead, out, 1.
- MemReadData, in, DW: the memory updates it at the posedge on which it samples a command.
REQ-007 SHALL have Busy, out, 1: high in every state other than IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE and RESP.
REQ-009 SHALL arbitrate in IDLE and in RESP when ReqA|ReqB is sampled high at an edge: select the winner, register its Addr/WData/Write into MemAddress/MemWriteData/MemWrite, set MemRead=~Write, pulse the winner's Gnt for the following cycle, and go to ISSUE.
REQ-010 SHALL, in ISSUE, clear MemWrite/MemRead at the next edge and go to RESP; the memory samples the command at that edge.
REQ-011 SHALL, in RESP, capture MemReadData into the winner's RData at the next edge, pulse that winner's Valid for one cycle, and then arbitrate again (REQ-009) or go to IDLE if no request.
REQ-012 SHALL have latency: Gnt in cycle after accept edge E0; Valid in cycle after E2; peak throughput one access per 2 cycles.
REQ-013 SHALL return the written value in RData with Valid for a write.
REQ-014 SHALL require requesters to hold Req/Write/Addr/WData stable until Gnt; Req dropped before being sampled is ignored; Req held after Gnt is a new request.
REQ-015 SHALL never assert MemWrite and MemRead together, and never assert both Gnt or both Valid together.
REQ-016 SHALL hold RDataX unchanged except on that port's Valid.
REQ-017 SHALL ignore Req in ISSUE; it is sampled at the next arbitration edge.

Reset
REQ-018 SHALL, on Rst_n low, immediately set state IDLE, all outputs 0, and the round-robin pointer to A.
REQ-019 SHALL abandon an access in flight on reset mid-operation: if Rst_n falls before E1, no memory write occurs and no Valid is issued after release.
REQ-020 SHALL accept the first request at the first posedge after Rst_n rises.

Configuration
REQ-021 SHALL, with ARB_ROUND_ROBIN_EN defined, grant the port not granted last when both request; the pointer updates on each grant.
REQ-022 SHALL, without ARB_ROUND_ROBIN_EN, use fixed priority, A always wins, and have no pointer register.

Structure
REQ-023 SHALL place the state enum (IDLE/ISSUE/RESP) and the AW/DW defaults in shared package dm_arb_pkg.
REQ-024 SHALL put the winner select in one sub-module, dm_arb_pick (ReqA, ReqB, pointer -> winner); the FSM and datapath stay in the top.

Verification
REQ-025 SHALL cover: ReqA write Addr=993 WData=22 -> GntA cycle1, MemWrite=1 cycle1 only, ValidA cycle3 with RDataA=22.
REQ-026 SHALL cover: then ReqB read Addr=993 -> GntB, MemRead=1 one cycle, ValidB with RDataB=22, RDataA unchanged.
REQ-027 SHALL cover: ReqA and ReqB held high continuously -> with macro, grants alternate A,B,A,B, one every 2 cycles; without macro, A only and B starved.
REQ-028 SHALL cover: write Addr=1023 WData=-20, Rst_n low in ISSUE before E1 -> all outputs 0, no Valid, a later read of 1023 returns the old value.
REQ-029 SHALL cover: ReqA pulsed for one cycle while in ISSUE -> no grant.
REQ-030 SHALL cover: all outputs 0 and Busy=0 during reset.
